// File: rtl/user_wb_io_regs.sv
// Wishbone slave register block for the Caravel user area: drives the 38 user
// pads, samples them back through a synchronizer, and raises user interrupts.
module user_wb_io_regs #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter logic [31:0] ADDR_MASK = 32'hFFFF_0000,
  parameter logic [31:0] ID_VALUE  = 32'h5742_0001
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  input  logic [37:0] io_in,
  output logic [37:0] io_out,
  output logic [37:0] io_oeb,
  output logic [2:0]  irq
);

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  be);
    logic [31:0] result;
    for (int i = 0; i < 4; i++) begin
      result[8*i +: 8] = be[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
    end
    return result;
  endfunction

  logic        sel_s, wr_s, rd_s;
  logic [5:0]  idx_s;
  logic        ack_r;
  logic [31:0] dat_r, rdata_s;
  logic [31:0] scratch0_r, scratch1_r, out_lo_r, oeb_lo_r, cycles_r;
  logic [5:0]  out_hi_r, oeb_hi_r;
  logic [2:0]  irq_stat_r;
  logic [37:0] sync1_r, sync2_r;

  assign sel_s = wbs_cyc_i & wbs_stb_i & ((wbs_adr_i & ADDR_MASK) == BASE_ADDR);
  assign idx_s = wbs_adr_i[7:2];
  // The cycle right after an ack is dead, so held strobes see ack every other cycle.
  assign wr_s  = sel_s & ~ack_r & wbs_we_i;
  assign rd_s  = sel_s & ~ack_r & ~wbs_we_i;

  // Read data multiplexer over the register map.
  always_comb begin
    rdata_s = 32'd0;
    case (idx_s)
      6'h00:   rdata_s = scratch0_r;
      6'h01:   rdata_s = scratch1_r;
      6'h02:   rdata_s = out_lo_r;
      6'h03:   rdata_s = {26'd0, out_hi_r};
      6'h04:   rdata_s = oeb_lo_r;
      6'h05:   rdata_s = {26'd0, oeb_hi_r};
      6'h06:   rdata_s = sync2_r[31:0];
      6'h07:   rdata_s = {26'd0, sync2_r[37:32]};
      6'h08:   rdata_s = ID_VALUE;
      6'h09:   rdata_s = cycles_r;
      6'h0A:   rdata_s = {29'd0, irq_stat_r};
      default: rdata_s = 32'd0;
    endcase
  end

  // Bus handshake: single-cycle ack with registered read data.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ack_r <= 1'b0;
      dat_r <= 32'd0;
    end else begin
      ack_r <= sel_s & ~ack_r;
      dat_r <= rd_s ? rdata_s : 32'd0;
    end
  end

  // Writable registers; writes commit on the edge that raises ack.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      scratch0_r <= 32'd0;
      scratch1_r <= 32'd0;
      out_lo_r   <= 32'd0;
      out_hi_r   <= 6'd0;
      oeb_lo_r   <= 32'hFFFF_FFFF;
      oeb_hi_r   <= 6'h3F;
      irq_stat_r <= 3'd0;
    end else if (wr_s) begin
      case (idx_s)
        6'h00:   scratch0_r <= merge_bytes(scratch0_r, wbs_dat_i, wbs_sel_i);
        6'h01:   scratch1_r <= merge_bytes(scratch1_r, wbs_dat_i, wbs_sel_i);
        6'h02:   out_lo_r   <= merge_bytes(out_lo_r, wbs_dat_i, wbs_sel_i);
        6'h03:   out_hi_r   <= wbs_sel_i[0] ? wbs_dat_i[5:0] : out_hi_r;
        6'h04:   oeb_lo_r   <= merge_bytes(oeb_lo_r, wbs_dat_i, wbs_sel_i);
        6'h05:   oeb_hi_r   <= wbs_sel_i[0] ? wbs_dat_i[5:0] : oeb_hi_r;
        6'h0A:   irq_stat_r <= irq_stat_r & ~(wbs_dat_i[2:0] & {3{wbs_sel_i[0]}});
        6'h0B:   irq_stat_r <= irq_stat_r | (wbs_dat_i[2:0] & {3{wbs_sel_i[0]}});
        default: irq_stat_r <= irq_stat_r;
      endcase
    end
  end

  // Pad input synchronizer and free-running cycle counter.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      sync1_r  <= 38'd0;
      sync2_r  <= 38'd0;
      cycles_r <= 32'd0;
    end else begin
      sync1_r  <= io_in;
      sync2_r  <= sync1_r;
      cycles_r <= cycles_r + 32'd1;
    end
  end

  assign wbs_ack_o = ack_r;
  assign wbs_dat_o = dat_r;
  assign io_out    = {out_hi_r, out_lo_r};
  assign io_oeb    = {oeb_hi_r, oeb_lo_r};
  assign irq       = irq_stat_r;

endmodule

// File: tb/tb_user_wb_io_regs.sv
// Directed self-checking bench for user_wb_io_regs.
module tb_user_wb_io_regs;

  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam logic [31:0] ID   = 32'h5742_0001;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = 32'd0, dat = 32'd0;
  logic        ack;
  logic [31:0] dat_o;
  logic [37:0] io_in = 38'd0;
  logic [37:0] io_out, io_oeb;
  logic [2:0]  irq;

  int errors = 0;
  int checks = 0;

  user_wb_io_regs dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(dat), .wbs_ack_o(ack), .wbs_dat_o(dat_o),
    .io_in(io_in), .io_out(io_out), .io_oeb(io_oeb), .irq(irq)
  );

  always #5 clk = ~clk;

  // One bus transfer; lat is the number of edges until ack (8 means no ack within the timeout).
  task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] be, output logic [31:0] rdata, output int lat);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat = d; sel = be;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!ack && lat < 8);
    rdata = dat_o;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    int lat;
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    checks++; if (io_oeb !== 38'h3F_FFFF_FFFF) begin errors++; $display("FAIL reset_oeb: got %h expected %h", io_oeb, 38'h3F_FFFF_FFFF); end
    checks++; if (io_out !== 38'd0) begin errors++; $display("FAIL reset_out: got %h expected 0", io_out); end
    checks++; if (irq !== 3'd0) begin errors++; $display("FAIL reset_irq: got %b expected 000", irq); end
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b expected 0", ack); end
    @(negedge clk); rst = 1'b0;
    wb_xfer(1'b0, BASE + 32'h20, 32'd0, 4'hF, rd, lat);
    checks++; if (rd !== ID) begin errors++; $display("FAIL read_id: got %h expected %h", rd, ID); end
    checks++; if (lat !== 1) begin errors++; $display("FAIL id_latency: got %0d expected 1", lat); end
  endtask

  task automatic test_status_pins();
    logic [31:0] rd;
    int lat;
    wb_xfer(1'b1, BASE + 32'h10, 32'd0, 4'hF, rd, lat);
    wb_xfer(1'b1, BASE + 32'h14, 32'd0, 4'hF, rd, lat);
    checks++; if (io_oeb !== 38'd0) begin errors++; $display("FAIL oeb_clear: got %h expected 0", io_oeb); end
    wb_xfer(1'b1, BASE + 32'h08, 32'h0000_0000, 4'hF, rd, lat);
    checks++; if (io_out[25:20] !== 6'd0) begin errors++; $display("FAIL progress0: got %h expected 0", io_out[25:20]); end
    wb_xfer(1'b1, BASE + 32'h08, 32'h0010_0000, 4'hF, rd, lat);
    checks++; if (io_out[25:20] !== 6'd1) begin errors++; $display("FAIL progress1: got %h expected 1", io_out[25:20]); end
    checks++; if (lat !== 1) begin errors++; $display("FAIL write_latency: got %0d expected 1", lat); end
    wb_xfer(1'b1, BASE + 32'h0C, 32'h0000_0010, 4'hF, rd, lat);
    checks++; if (io_out[37:36] !== 2'b01) begin errors++; $display("FAIL done_flags: got %b expected 01", io_out[37:36]); end
    wb_xfer(1'b1, BASE + 32'h0C, 32'hFFFF_FFFF, 4'hF, rd, lat);
    wb_xfer(1'b0, BASE + 32'h0C, 32'd0, 4'hF, rd, lat);
    checks++; if (rd !== 32'h0000_003F) begin errors++; $display("FAIL out_hi_read: got %h expected 0000003f", rd); end
  endtask

  task automatic test_byte_enables();
    logic [31:0] rd;
    int lat;
    wb_xfer(1'b1, BASE + 32'h00, 32'hFFFF_FFFF, 4'hF, rd, lat);
    wb_xfer(1'b1, BASE + 32'h00, 32'h1234_5678, 4'b0101, rd, lat);
    wb_xfer(1'b0, BASE + 32'h00, 32'd0, 4'hF, rd, lat);
    checks++; if (rd !== 32'hFF34_FF78) begin errors++; $display("FAIL byte_lanes: got %h expected ff34ff78", rd); end
    wb_xfer(1'b1, BASE + 32'h00, 32'h0000_0000, 4'b0000, rd, lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL sel0_ack: got latency %0d expected 1", lat); end
    wb_xfer(1'b0, BASE + 32'h02, 32'd0, 4'hF, rd, lat);
    checks++; if (rd !== 32'hFF34_FF78) begin errors++; $display("FAIL sel0_noeffect: got %h expected ff34ff78", rd); end
    wb_xfer(1'b1, BASE + 32'h20, 32'h0, 4'hF, rd, lat);
    wb_xfer(1'b0, BASE + 32'h20, 32'd0, 4'hF, rd, lat);
    checks++; if (rd !== ID) begin errors++; $display("FAIL id_ro: got %h expected %h", rd, ID); end
  endtask

  task automatic test_input_path();
    logic [31:0] rd;
    int lat;
    @(negedge clk);
    io_in = 38'h2A_DEAD_BEEF;
    wb_xfer(1'b0, BASE + 32'h18, 32'd0, 4'hF, rd, lat);
    checks++; if (rd !== 32'd0) begin errors++; $display("FAIL in_sync_delay: got %h expected 0", rd); end
    wb_xfer(1'b0, BASE + 32'h18, 32'd0, 4'hF, rd, lat);
    checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL in_lo: got %h expected deadbeef", rd); end
    wb_xfer(1'b0, BASE + 32'h1C, 32'd0, 4'hF, rd, lat);
    checks++; if (rd !== 32'h0000_002A) begin errors++; $display("FAIL in_hi: got %h expected 0000002a", rd); end
  endtask

  task automatic test_cycles();
    logic [31:0] c0, c1;
    int lat;
    wb_xfer(1'b0, BASE + 32'h24, 32'd0, 4'hF, c0, lat);
    wb_xfer(1'b0, BASE + 32'h24, 32'd0, 4'hF, c1, lat);
    checks++; if (c1 - c0 !== 32'd2) begin errors++; $display("FAIL cycles_delta: got %0d expected 2", c1 - c0); end
  endtask

  task automatic test_irq();
    logic [31:0] rd;
    int lat;
    wb_xfer(1'b1, BASE + 32'h2C, 32'h0000_0005, 4'hF, rd, lat);
    checks++; if (irq !== 3'b101) begin errors++; $display("FAIL irq_set: got %b expected 101", irq); end
    wb_xfer(1'b0, BASE + 32'h2C, 32'd0, 4'hF, rd, lat);
    checks++; if (rd !== 32'd0) begin errors++; $display("FAIL irq_set_read: got %h expected 0", rd); end
    wb_xfer(1'b0, BASE + 32'h28, 32'd0, 4'hF, rd, lat);
    checks++; if (rd !== 32'd5) begin errors++; $display("FAIL irq_stat_read: got %h expected 5", rd); end
    wb_xfer(1'b1, BASE + 32'h28, 32'h0000_0001, 4'hF, rd, lat);
    checks++; if (irq !== 3'b100) begin errors++; $display("FAIL irq_w1c: got %b expected 100", irq); end
    wb_xfer(1'b0, BASE + 32'h40, 32'd0, 4'hF, rd, lat);
    checks++; if (rd !== 32'd0 || lat !== 1) begin errors++; $display("FAIL unmapped: got %h lat %0d expected 0 lat 1", rd, lat); end
  endtask

  task automatic test_back_to_back();
    logic exp_ack;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE + 32'h20; sel = 4'hF;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      exp_ack = (i % 2 == 0);
      checks++; if (ack !== exp_ack || dat_o !== (exp_ack ? ID : 32'd0)) begin
        errors++; $display("FAIL b2b_%0d: got ack %b dat %h expected ack %b", i, ack, dat_o, exp_ack);
      end
    end
    cyc = 1'b0; stb = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_abort_window();
    logic [31:0] rd;
    int lat;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE + 32'h04; dat = 32'hCAFE_F00D; sel = 4'hF;
    #2 rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL abort_ack: got %b expected 0", ack); end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(negedge clk); rst = 1'b0;
    wb_xfer(1'b0, BASE + 32'h04, 32'd0, 4'hF, rd, lat);
    checks++; if (rd !== 32'd0) begin errors++; $display("FAIL abort_nowrite: got %h expected 0", rd); end
    checks++; if (io_oeb !== 38'h3F_FFFF_FFFF) begin errors++; $display("FAIL abort_oeb: got %h expected 3fffffffff", io_oeb); end
    wb_xfer(1'b0, 32'h3001_0000, 32'd0, 4'hF, rd, lat);
    checks++; if (lat !== 8) begin errors++; $display("FAIL window_noack: got ack after %0d cycles expected none", lat); end
  endtask

  initial begin
    test_reset();
    test_status_pins();
    test_byte_enables();
    test_input_path();
    test_cycles();
    test_irq();
    test_back_to_back();
    test_abort_window();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
